axis_weight_preload: RTL and testbench
======================================

Name: axis_weight_preload

Overview:
- AXI4-Stream slave that receives narrow weight beats from the DMA.
- Packs them LSB-first into 5*MAC_NUM-bit weight words and buffers the words in a show-ahead FIFO of AXIS_PRELOAD_FIFO_DEPTH entries.
- Producer side of the preload interface: supplies weight_from_preload and axis_fifo_cnt to the BRAM write controller, and pops on that controller's axis_fifo_read.

Parameters:
- MAC_NUM, 256, number of MACs; weight word width = 5*MAC_NUM.
- AXIS_DATA_WIDTH, 64, s_axis_tdata width; 5*MAC_NUM must be an integer multiple of it.
- AXIS_PRELOAD_FIFO_DEPTH, 4, FIFO entries; power of two, at least 2.
- bit_num, clogb2(AXIS_PRELOAD_FIFO_DEPTH-1), count MSB index; count width is bit_num+1.

Ports:
- clk  in  1  clock (already decided)
- rst_n  in  1  reset, asynchronous, active-low (already decided)
- s_axis_tdata  in  AXIS_DATA_WIDTH  stream data
- s_axis_tvalid  in  1  stream valid
- s_axis_tlast  in  1  end of weight block; flushes a partial word
- s_axis_tready  out  1  stream ready
- preload_clear  in  1  synchronous flush, pulsed with transfer_start
- axis_fifo_read  in  1  pop strobe from the BRAM controller
- weight_from_preload  out  5*MAC_NUM  FIFO head word (show-ahead)
- axis_fifo_cnt  out  bit_num+1  words held, range 0..DEPTH
- fifo_full  out  1  axis_fifo_cnt == DEPTH

Behaviour:
- Reset values: s_axis_tready=0, axis_fifo_cnt=0, fifo_full=0, weight_from_preload=0. Packer beat counter and pointers are 0.
- BEATS = 5*MAC_NUM/AXIS_DATA_WIDTH.
- s_axis_tready = !fifo_full && !preload_clear. It is a registered-state function only and never depends on axis_fifo_read.
- Accepted beat = tvalid && tready. Beat k (0..BEATS-1) lands at bits [k*W +: W] of the pack register, then the beat counter increments.
- Completing beat: beat_cnt==BEATS-1, or tlast. On it, the word is pushed in the same cycle and beat_cnt returns to 0.
- On a tlast-completed partial word, unfilled upper bits are zero.
- Latency: a push at edge t makes the word visible (and the count incremented) at t+1.
- Pop occurs when axis_fifo_read && axis_fifo_cnt!=0. A read while empty is ignored; the controller strobes read in WS0/WS1 regardless of count.
- Popped word leaves the head after the edge; the next entry, or 0 if now empty, appears at t+1.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- A push cannot occur while full, because tready is low.
- weight_from_preload is mem[rd_ptr] when count!=0, and 0 when empty.
- Pointers are log2(DEPTH) bits and wrap naturally. Count saturates by construction and never exceeds DEPTH.
- preload_clear has priority over push and pop:
  - count, pointers and beat_cnt go to 0;
  - the partial word is discarded;
  - the beat presented in that cycle is not accepted (tready=0).
- Reset mid-transfer: everything returns to reset values immediately (async). No beat is accepted until rst_n is released.

Optional Feature:
PRELOAD_STATS_EN
- Defined:
  - adds outputs stat_beats[31:0] (accepted beats) and stat_pad_words[15:0] (words completed by tlast with beat_cnt<BEATS-1);
  - both wrap modulo 2^N;
  - both are cleared by rst_n and preload_clear.
- Undefined: ports and logic are absent; core behaviour is identical.

Decomposition:
- Shared package weight_preload_pkg holds:
  - clogb2 function;
  - BEATS calculation;
  - weight word width constant 5*MAC_NUM.
- One sub-module, preload_sync_fifo:
  - single-clock, show-ahead, parameterised width/depth;
  - ports push, pop, din, dout, count, full.
- The packer and tready logic stay in the top.

Test Plan (MAC_NUM=16, AXIS_DATA_WIDTH=16, DEPTH=4, BEATS=5):
- Pack order: five beats 0x0001..0x0005, no read -> next cycle cnt=1 and weight_from_preload=0x00050004000300020001.
- Partial tlast: beats 0xAAAA, 0xBBBB(tlast) -> word 0x0000000000BBBBAAAA; stat_pad_words=1 when PRELOAD_STATS_EN.
- Backpressure: stream 25 beats with no reads -> after 20 beats cnt=4, fifo_full=1, tready=0. One read -> tready=1 next cycle, the remaining 5 beats complete, cnt=4.
- Simultaneous push/pop at cnt=2 -> cnt stays 2, head advances to the 2nd word. axis_fifo_read at cnt=0 -> cnt stays 0, output 0.
- preload_clear with cnt=3 and 2 beats pending, concurrent tvalid -> cnt=0, tready=0 that cycle. The next 5 beats form a fresh word beginning at bit 0.
- Assert rst_n low for 1 cycle during beat 3 -> all outputs 0. The first beat after release lands at bits [15:0].

Source files
------------

// File: rtl/weight_preload_pkg.sv
// Shared sizing helpers for the AXI-Stream weight preload path.
package weight_preload_pkg;

  localparam int unsigned WEIGHT_BITS_PER_MAC = 5;

  // Bits needed to represent value (ceil(log2(value+1))).
  function automatic int unsigned clogb2(input int unsigned value);
    int unsigned v;
    int unsigned r;
    v = value;
    r = 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  function automatic int unsigned word_width(input int unsigned mac_num);
    return WEIGHT_BITS_PER_MAC * mac_num;
  endfunction

  function automatic int unsigned beats_per_word(input int unsigned mac_num,
                                                 input int unsigned data_w);
    return word_width(mac_num) / data_w;
  endfunction

endpackage

// File: rtl/preload_sync_fifo.sv
// Single-clock show-ahead FIFO; dout is the head entry, or zero when empty.
module preload_sync_fifo
  import weight_preload_pkg::*;
#(
  parameter  int unsigned WIDTH = 1280,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = clogb2(DEPTH - 1),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CNT_W-1:0] count,
  output logic             full
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push_ok_c;
  logic             pop_ok_c;

  assign full      = (cnt_q == CNT_W'(DEPTH));
  assign count     = cnt_q;
  assign dout      = (cnt_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign push_ok_c = push && !full && !clr;
  assign pop_ok_c  = pop && (cnt_q != '0) && !clr;

  // Pointer/count update; clear overrides push and pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push_ok_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_ok_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_ok_c, pop_ok_c})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: an empty FIFO never exposes it.
  always_ff @(posedge clk) begin
    if (push_ok_c) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/axis_weight_preload.sv
// AXI-Stream weight packer feeding a show-ahead preload FIFO.
// Optional statistics counters are enabled with `define PRELOAD_STATS_EN.
module axis_weight_preload
  import weight_preload_pkg::*;
#(
  parameter  int unsigned MAC_NUM                 = 256,
  parameter  int unsigned AXIS_DATA_WIDTH         = 64,
  parameter  int unsigned AXIS_PRELOAD_FIFO_DEPTH = 4,
  localparam int unsigned bit_num                 = clogb2(AXIS_PRELOAD_FIFO_DEPTH - 1),
  localparam int unsigned WORD_W                  = word_width(MAC_NUM)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                       s_axis_tvalid,
  input  logic                       s_axis_tlast,
  output logic                       s_axis_tready,
  input  logic                       preload_clear,
  input  logic                       axis_fifo_read,
  output logic [WORD_W-1:0]          weight_from_preload,
`ifdef PRELOAD_STATS_EN
  output logic [31:0]                stat_beats,
  output logic [15:0]                stat_pad_words,
`endif
  output logic [bit_num:0]           axis_fifo_cnt,
  output logic                       fifo_full
);

  localparam int unsigned BEATS  = beats_per_word(MAC_NUM, AXIS_DATA_WIDTH);
  localparam int unsigned BCNT_W = (BEATS > 1) ? clogb2(BEATS - 1) : 1;

  logic [WORD_W-1:0] pack_q, pack_d;
  logic [WORD_W-1:0] word_c;
  logic [BCNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic              rdy_en_q;
  logic              accept_c;
  logic              last_beat_c;
  logic              complete_c;

  // Ready is held low through reset and for the clear cycle.
  assign s_axis_tready = rdy_en_q && !fifo_full && !preload_clear;
  assign accept_c      = s_axis_tvalid && s_axis_tready;
  assign last_beat_c   = (beat_cnt_q == BCNT_W'(BEATS - 1));
  assign complete_c    = accept_c && (last_beat_c || s_axis_tlast);

  // Merge the current beat into the partially packed word.
  always_comb begin
    word_c = pack_q;
    for (int k = 0; k < BEATS; k++) begin
      if (beat_cnt_q == BCNT_W'(k)) word_c[k*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH] = s_axis_tdata;
    end
  end

  always_comb begin
    pack_d     = pack_q;
    beat_cnt_d = beat_cnt_q;
    if (preload_clear || complete_c) begin
      pack_d     = '0;
      beat_cnt_d = '0;
    end else if (accept_c) begin
      pack_d     = word_c;
      beat_cnt_d = beat_cnt_q + BCNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pack_q     <= '0;
      beat_cnt_q <= '0;
      rdy_en_q   <= 1'b0;
    end else begin
      pack_q     <= pack_d;
      beat_cnt_q <= beat_cnt_d;
      rdy_en_q   <= 1'b1;
    end
  end

  preload_sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (AXIS_PRELOAD_FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (preload_clear),
    .push  (complete_c),
    .pop   (axis_fifo_read),
    .din   (word_c),
    .dout  (weight_from_preload),
    .count (axis_fifo_cnt),
    .full  (fifo_full)
  );

`ifdef PRELOAD_STATS_EN
  logic [31:0] stat_beats_q, stat_beats_d;
  logic [15:0] stat_pad_q, stat_pad_d;

  // Pad words are tlast-terminated words that ended short of a full beat set.
  always_comb begin
    stat_beats_d = stat_beats_q;
    stat_pad_d   = stat_pad_q;
    if (preload_clear) begin
      stat_beats_d = '0;
      stat_pad_d   = '0;
    end else begin
      if (accept_c) stat_beats_d = stat_beats_q + 32'd1;
      if (complete_c && s_axis_tlast && !last_beat_c) stat_pad_d = stat_pad_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_beats_q <= '0;
      stat_pad_q   <= '0;
    end else begin
      stat_beats_q <= stat_beats_d;
      stat_pad_q   <= stat_pad_d;
    end
  end

  assign stat_beats     = stat_beats_q;
  assign stat_pad_words = stat_pad_q;
`endif

endmodule

// File: tb/tb_axis_weight_preload.sv
// Scoreboard bench for axis_weight_preload at MAC_NUM=16, 16-bit stream, depth 4.
module tb_axis_weight_preload;

  localparam int unsigned MAC_NUM = 16;
  localparam int unsigned DW      = 16;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned WW      = 5 * MAC_NUM;
  localparam int unsigned BEATS   = WW / DW;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tlast;
  logic          s_axis_tready;
  logic          preload_clear;
  logic          axis_fifo_read;
  logic [WW-1:0] weight_from_preload;
  logic [2:0]    axis_fifo_cnt;
  logic          fifo_full;
`ifdef PRELOAD_STATS_EN
  logic [31:0]   stat_beats;
  logic [15:0]   stat_pad_words;
`endif

  logic [WW-1:0] sb[$];
  logic [WW-1:0] exp_w;
  int n_pass;
  int n_total;

  axis_weight_preload #(
    .MAC_NUM                 (MAC_NUM),
    .AXIS_DATA_WIDTH         (DW),
    .AXIS_PRELOAD_FIFO_DEPTH (DEPTH)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .s_axis_tdata        (s_axis_tdata),
    .s_axis_tvalid       (s_axis_tvalid),
    .s_axis_tlast        (s_axis_tlast),
    .s_axis_tready       (s_axis_tready),
    .preload_clear       (preload_clear),
    .axis_fifo_read      (axis_fifo_read),
    .weight_from_preload (weight_from_preload),
`ifdef PRELOAD_STATS_EN
    .stat_beats          (stat_beats),
    .stat_pad_words      (stat_pad_words),
`endif
    .axis_fifo_cnt       (axis_fifo_cnt),
    .fifo_full           (fifo_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one beat from a negedge; returns at the negedge after acceptance.
  task automatic send_beat(input logic [DW-1:0] d, input logic last);
    int waited;
    s_axis_tdata  = d;
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
    #1;
    waited = 0;
    while (!s_axis_tready && waited < 50) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!s_axis_tready) begin
      n_total++;
      $display("FAIL beat_timeout data=%h tready stayed %b, required 1", d, s_axis_tready);
    end else begin
      @(posedge clk);
    end
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  // Full word of BEATS beats with base value; expected word queued.
  task automatic send_word(input logic [DW-1:0] base);
    logic [WW-1:0] w;
    logic [DW-1:0] d;
    w = '0;
    for (int b = 0; b < BEATS; b++) begin
      d = base + DW'(b);
      w[b*DW +: DW] = d;
      send_beat(d, 1'b0);
    end
    sb.push_back(w);
  endtask

  task automatic pulse_read();
    axis_fifo_read = 1'b1;
    @(posedge clk);
    @(negedge clk);
    axis_fifo_read = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata = 16'h5555;
    repeat (3) @(negedge clk);
    #1;
    n_total++; if (s_axis_tready !== 1'b0) $display("FAIL rst_tready got %b exp 0", s_axis_tready); else n_pass++;
    n_total++; if (axis_fifo_cnt !== 3'd0) $display("FAIL rst_cnt got %0d exp 0", axis_fifo_cnt); else n_pass++;
    n_total++; if (fifo_full !== 1'b0) $display("FAIL rst_full got %b exp 0", fifo_full); else n_pass++;
    n_total++; if (weight_from_preload !== '0) $display("FAIL rst_word got %h exp 0", weight_from_preload); else n_pass++;
    s_axis_tvalid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_pack_order();
    send_word(16'h0001);
    n_total++; if (axis_fifo_cnt !== 3'd1) $display("FAIL pack_cnt got %0d exp 1", axis_fifo_cnt); else n_pass++;
    exp_w = sb.pop_front();
    n_total++;
    if (weight_from_preload !== exp_w || exp_w !== 80'h0005_0004_0003_0002_0001)
      $display("FAIL pack_word got %h exp %h", weight_from_preload, exp_w);
    else n_pass++;
    pulse_read();
    n_total++; if (axis_fifo_cnt !== 3'd0) $display("FAIL pack_pop_cnt got %0d exp 0", axis_fifo_cnt); else n_pass++;
    n_total++; if (weight_from_preload !== '0) $display("FAIL pack_empty_word got %h exp 0", weight_from_preload); else n_pass++;
  endtask

  task automatic test_partial_tlast();
    send_beat(16'hAAAA, 1'b0);
    send_beat(16'hBBBB, 1'b1);
    sb.push_back(80'h0000_0000_0000_BBBB_AAAA);
    n_total++; if (axis_fifo_cnt !== 3'd1) $display("FAIL tlast_cnt got %0d exp 1", axis_fifo_cnt); else n_pass++;
`ifdef PRELOAD_STATS_EN
    n_total++; if (stat_pad_words !== 16'd1) $display("FAIL tlast_pad got %0d exp 1", stat_pad_words); else n_pass++;
`endif
    exp_w = sb.pop_front();
    n_total++; if (weight_from_preload !== exp_w) $display("FAIL tlast_word got %h exp %h", weight_from_preload, exp_w); else n_pass++;
    pulse_read();
  endtask

  task automatic test_backpressure();
    for (int w = 0; w < 4; w++) send_word(16'h0100 * DW'(w + 1));
    s_axis_tdata  = 16'h0500;
    s_axis_tvalid = 1'b1;
    #1;
    n_total++; if (axis_fifo_cnt !== 3'd4) $display("FAIL bp_cnt got %0d exp 4", axis_fifo_cnt); else n_pass++;
    n_total++; if (fifo_full !== 1'b1) $display("FAIL bp_full got %b exp 1", fifo_full); else n_pass++;
    n_total++; if (s_axis_tready !== 1'b0) $display("FAIL bp_tready got %b exp 0", s_axis_tready); else n_pass++;
    repeat (2) @(negedge clk);
    exp_w = sb.pop_front();
    n_total++; if (weight_from_preload !== exp_w) $display("FAIL bp_head got %h exp %h", weight_from_preload, exp_w); else n_pass++;
    pulse_read();
    #1;
    n_total++; if (s_axis_tready !== 1'b1) $display("FAIL bp_tready_after_read got %b exp 1", s_axis_tready); else n_pass++;
    send_word(16'h0500);
    n_total++; if (axis_fifo_cnt !== 3'd4) $display("FAIL bp_refill_cnt got %0d exp 4", axis_fifo_cnt); else n_pass++;
    while (sb.size() != 0) begin
      exp_w = sb.pop_front();
      n_total++; if (weight_from_preload !== exp_w) $display("FAIL bp_drain got %h exp %h", weight_from_preload, exp_w); else n_pass++;
      pulse_read();
    end
  endtask

  task automatic test_back_to_back();
    logic [WW-1:0] w3;
    send_word(16'h1000);
    send_word(16'h2000);
    w3 = '0;
    for (int b = 0; b < BEATS - 1; b++) begin
      w3[b*DW +: DW] = 16'h3000 + DW'(b);
      send_beat(16'h3000 + DW'(b), 1'b0);
    end
    w3[(BEATS-1)*DW +: DW] = 16'h3000 + DW'(BEATS - 1);
    s_axis_tdata   = 16'h3000 + DW'(BEATS - 1);
    s_axis_tvalid  = 1'b1;
    axis_fifo_read = 1'b1;
    #1;
    exp_w = sb.pop_front();
    n_total++; if (weight_from_preload !== exp_w) $display("FAIL b2b_head0 got %h exp %h", weight_from_preload, exp_w); else n_pass++;
    @(posedge clk);
    @(negedge clk);
    s_axis_tvalid  = 1'b0;
    axis_fifo_read = 1'b0;
    sb.push_back(w3);
    n_total++; if (axis_fifo_cnt !== 3'd2) $display("FAIL b2b_cnt got %0d exp 2", axis_fifo_cnt); else n_pass++;
    while (sb.size() != 0) begin
      exp_w = sb.pop_front();
      n_total++; if (weight_from_preload !== exp_w) $display("FAIL b2b_drain got %h exp %h", weight_from_preload, exp_w); else n_pass++;
      pulse_read();
    end
    pulse_read();
    n_total++; if (axis_fifo_cnt !== 3'd0) $display("FAIL empty_read_cnt got %0d exp 0", axis_fifo_cnt); else n_pass++;
    n_total++; if (weight_from_preload !== '0) $display("FAIL empty_read_word got %h exp 0", weight_from_preload); else n_pass++;
  endtask

  task automatic test_clear();
    for (int w = 0; w < 3; w++) send_word(16'h4000 + 16'h0010 * DW'(w));
    send_beat(16'hEEE0, 1'b0);
    send_beat(16'hEEE1, 1'b0);
    sb.delete();
    preload_clear = 1'b1;
    s_axis_tdata  = 16'hDEAD;
    s_axis_tvalid = 1'b1;
    #1;
    n_total++; if (s_axis_tready !== 1'b0) $display("FAIL clr_tready got %b exp 0", s_axis_tready); else n_pass++;
    @(posedge clk);
    @(negedge clk);
    preload_clear = 1'b0;
    s_axis_tvalid = 1'b0;
    n_total++; if (axis_fifo_cnt !== 3'd0) $display("FAIL clr_cnt got %0d exp 0", axis_fifo_cnt); else n_pass++;
    n_total++; if (weight_from_preload !== '0) $display("FAIL clr_word got %h exp 0", weight_from_preload); else n_pass++;
    send_word(16'h0011);
    exp_w = sb.pop_front();
    n_total++; if (weight_from_preload !== exp_w) $display("FAIL clr_fresh_word got %h exp %h", weight_from_preload, exp_w); else n_pass++;
`ifdef PRELOAD_STATS_EN
    n_total++; if (stat_beats !== 32'd5) $display("FAIL clr_stat_beats got %0d exp 5", stat_beats); else n_pass++;
`endif
    pulse_read();
  endtask

  task automatic test_reset_mid();
    send_word(16'h6000);
    for (int b = 0; b < 3; b++) send_beat(16'h7000 + DW'(b), 1'b0);
    sb.delete();
    s_axis_tdata  = 16'h7003;
    s_axis_tvalid = 1'b1;
    rst_n         = 1'b0;
    #1;
    n_total++; if (axis_fifo_cnt !== 3'd0) $display("FAIL rstmid_cnt got %0d exp 0", axis_fifo_cnt); else n_pass++;
    n_total++; if (weight_from_preload !== '0) $display("FAIL rstmid_word got %h exp 0", weight_from_preload); else n_pass++;
    n_total++; if (s_axis_tready !== 1'b0) $display("FAIL rstmid_tready got %b exp 0", s_axis_tready); else n_pass++;
    @(negedge clk);
    rst_n         = 1'b1;
    s_axis_tvalid = 1'b0;
    @(negedge clk);
    send_word(16'h0021);
    exp_w = sb.pop_front();
    n_total++; if (weight_from_preload !== exp_w) $display("FAIL rstmid_fresh_word got %h exp %h", weight_from_preload, exp_w); else n_pass++;
    n_total++; if (axis_fifo_cnt !== 3'd1) $display("FAIL rstmid_fresh_cnt got %0d exp 1", axis_fifo_cnt); else n_pass++;
    pulse_read();
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    rst_n = 1'b0;
    s_axis_tdata = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
    preload_clear = 1'b0;
    axis_fifo_read = 1'b0;
    test_reset();
    test_pack_order();
    test_partial_tlast();
    test_backpressure();
    test_back_to_back();
    test_clear();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
